// File: rtl/cnn_pkg.sv
// Shared CNN constants and types, used by fully_connected and argmax_result.
// ARGMAX_MARGIN_EN additionally enables the saturating margin helper.
package cnn_pkg;

  localparam int NUM_CLS = 10;
  localparam int CLS_W   = 4;
  localparam int LOGIT_W = 32;
  localparam int FCNT_W  = 16;

  typedef logic signed [LOGIT_W-1:0] logit_t;
  typedef logic [CLS_W-1:0]          cls_t;

  typedef enum logic {
    ST_IDLE,
    ST_ACC
  } frame_state_t;

`ifdef ARGMAX_MARGIN_EN
  // hi >= lo always holds, so the extended difference is read as unsigned
  function automatic logic [LOGIT_W-1:0] sat_margin(input logit_t hi, input logit_t lo);
    logic [LOGIT_W:0] diff;
    diff = {hi[LOGIT_W-1], hi} - {lo[LOGIT_W-1], lo};
    sat_margin = diff[LOGIT_W] ? '1 : diff[LOGIT_W-1:0];
  endfunction
`endif

endpackage

// File: rtl/argmax_result_if.sv
// Logit-beat input stream and valid/ready result port of argmax_result.
// ARGMAX_MARGIN_EN adds res_margin to the result port.
interface argmax_result_if;
  import cnn_pkg::*;

  logic   in_valid;
  cls_t   in_cls;
  logit_t in_logit;
  logic   in_last;
  logic   res_valid;
  logic   res_ready;
  cls_t   res_cls;
  logit_t res_logit;
  logic   res_err;
`ifdef ARGMAX_MARGIN_EN
  logic [LOGIT_W-1:0] res_margin;

  modport master (
    output in_valid, in_cls, in_logit, in_last, res_ready,
    input  res_valid, res_cls, res_logit, res_err, res_margin
  );
  modport slave (
    input  in_valid, in_cls, in_logit, in_last, res_ready,
    output res_valid, res_cls, res_logit, res_err, res_margin
  );
`else
  modport master (
    output in_valid, in_cls, in_logit, in_last, res_ready,
    input  res_valid, res_cls, res_logit, res_err
  );
  modport slave (
    input  in_valid, in_cls, in_logit, in_last, res_ready,
    output res_valid, res_cls, res_logit, res_err
  );
`endif

endinterface

// File: rtl/argmax_cmp.sv
// Per-beat signed compare/update of the running (max, cls) and, with
// ARGMAX_MARGIN_EN, the second-highest logit. Ties keep the earlier class.
module argmax_cmp
  import cnn_pkg::*;
(
  input  logic   first,
  input  logit_t in_logit,
  input  cls_t   in_cls,
  input  logit_t max_val,
  input  cls_t   max_cls,
`ifdef ARGMAX_MARGIN_EN
  input  logit_t sec_val,
  input  logic   sec_vld,
  output logit_t nxt_sec_val,
  output logic   nxt_sec_vld,
`endif
  output logit_t nxt_max_val,
  output cls_t   nxt_max_cls
);

  logic take;

  assign take = first || (in_logit > max_val);

  always_comb begin
    nxt_max_val = take ? in_logit : max_val;
    nxt_max_cls = take ? in_cls   : max_cls;
  end

`ifdef ARGMAX_MARGIN_EN
  // A logit equal to the max lands in the second slot, giving a zero margin
  always_comb begin
    nxt_sec_val = sec_val;
    nxt_sec_vld = sec_vld;
    if (first) begin
      nxt_sec_val = '0;
      nxt_sec_vld = 1'b0;
    end else if (take) begin
      nxt_sec_val = max_val;
      nxt_sec_vld = 1'b1;
    end else if (!sec_vld || (in_logit > sec_val)) begin
      nxt_sec_val = in_logit;
      nxt_sec_vld = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/argmax_result.sv
// Argmax over one frame of NUM_CLS logits with integrity check, frame counter
// and a valid/ready result port. ARGMAX_MARGIN_EN adds res_margin.
module argmax_result
  import cnn_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  argmax_result_if.slave    bus,
  output logic              overrun,
  output logic [FCNT_W-1:0] frame_cnt
);

  frame_state_t state, state_nxt;
  logic beat, done, first, beat_err;

  cls_t   beat_cnt;
  logic   err_acc;
  logit_t max_val, nxt_max_val;
  cls_t   max_cls, nxt_max_cls;

  logic   res_valid;
  cls_t   res_cls;
  logit_t res_logit;
  logic   res_err;

`ifdef ARGMAX_MARGIN_EN
  logit_t sec_val, nxt_sec_val;
  logic   sec_vld, nxt_sec_vld;
  logic [LOGIT_W-1:0] res_margin;
`endif

  always_ff @(posedge clk) begin
    if (rst_n) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.in_valid && !bus.in_last) state_nxt = ST_ACC;
      ST_ACC:  if (bus.in_valid && bus.in_last)  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    beat  = bus.in_valid;
    done  = bus.in_valid && bus.in_last;
    first = bus.in_valid && (state == ST_IDLE);
  end

  // beat_cnt == NUM_CLS means the frame has already overflowed
  always_comb begin
    beat_err = (bus.in_cls != beat_cnt)
            || (beat_cnt == CLS_W'(NUM_CLS))
            || (bus.in_last && (beat_cnt != CLS_W'(NUM_CLS - 1)));
  end

  argmax_cmp u_cmp (
    .first       (first),
    .in_logit    (bus.in_logit),
    .in_cls      (bus.in_cls),
    .max_val     (max_val),
    .max_cls     (max_cls),
`ifdef ARGMAX_MARGIN_EN
    .sec_val     (sec_val),
    .sec_vld     (sec_vld),
    .nxt_sec_val (nxt_sec_val),
    .nxt_sec_vld (nxt_sec_vld),
`endif
    .nxt_max_val (nxt_max_val),
    .nxt_max_cls (nxt_max_cls)
  );

  always_ff @(posedge clk) begin
    if (rst_n || done) begin
      beat_cnt <= '0;
      err_acc  <= 1'b0;
      max_val  <= '0;
      max_cls  <= '0;
`ifdef ARGMAX_MARGIN_EN
      sec_val  <= '0;
      sec_vld  <= 1'b0;
`endif
    end else if (beat) begin
      beat_cnt <= (beat_cnt == CLS_W'(NUM_CLS)) ? beat_cnt : beat_cnt + 1'b1;
      err_acc  <= err_acc | beat_err;
      max_val  <= nxt_max_val;
      max_cls  <= nxt_max_cls;
`ifdef ARGMAX_MARGIN_EN
      sec_val  <= nxt_sec_val;
      sec_vld  <= nxt_sec_vld;
`endif
    end
  end

  // A completion always wins over a same-cycle transfer, keeping res_valid high
  always_ff @(posedge clk) begin
    if (rst_n) begin
      res_valid  <= 1'b0;
      res_cls    <= '0;
      res_logit  <= '0;
      res_err    <= 1'b0;
      overrun    <= 1'b0;
      frame_cnt  <= '0;
`ifdef ARGMAX_MARGIN_EN
      res_margin <= '0;
`endif
    end else if (done) begin
      res_valid  <= 1'b1;
      res_cls    <= nxt_max_cls;
      res_logit  <= nxt_max_val;
      res_err    <= err_acc | beat_err;
      frame_cnt  <= frame_cnt + 1'b1;
      if (res_valid && !bus.res_ready) overrun <= 1'b1;
`ifdef ARGMAX_MARGIN_EN
      res_margin <= sat_margin(nxt_max_val, nxt_sec_vld ? nxt_sec_val : nxt_max_val);
`endif
    end else if (res_valid && bus.res_ready) begin
      res_valid  <= 1'b0;
    end
  end

  assign bus.res_valid  = res_valid;
  assign bus.res_cls    = res_cls;
  assign bus.res_logit  = res_logit;
  assign bus.res_err    = res_err;
`ifdef ARGMAX_MARGIN_EN
  assign bus.res_margin = res_margin;
`endif

endmodule

// File: tb/tb_argmax_result.sv
// Directed self-checking bench for argmax_result; margin checks are active
// when ARGMAX_MARGIN_EN is defined.
module tb_argmax_result;
  import cnn_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              overrun;
  logic [FCNT_W-1:0] frame_cnt;
  int                checks = 0;
  int                errors = 0;
  logic              pre_last_valid;

  cls_t   frm_cls   [NUM_CLS];
  logit_t frm_logit [NUM_CLS];

  argmax_result_if bus();

  argmax_result dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .overrun   (overrun),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    end
  endtask

  // Drives n beats back to back; the final beat carries in_last when asked
  task automatic applyStimulus(input int n, input bit with_last);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_cls   = frm_cls[i];
      bus.in_logit = frm_logit[i];
      bus.in_last  = with_last && (i == n - 1);
      if (i == n - 1) pre_last_valid = bus.res_valid;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic pulseReset();
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
  endtask

  task automatic loadOrdered();
    for (int i = 0; i < NUM_CLS; i++) frm_cls[i] = cls_t'(i);
  endtask

  task automatic loadBasic();
    loadOrdered();
    frm_logit = '{5, -3, 100, 7, 100, 0, -1, 2, 3, 4};
  endtask

  task automatic checkResult(input string tag, input int cls, input logic [31:0] logit,
                             input bit err, input int fcnt);
    checkOutput({tag, "_valid"}, 32'(bus.res_valid), 32'd1);
    checkOutput({tag, "_cls"},   32'(bus.res_cls), 32'(cls));
    checkOutput({tag, "_logit"}, bus.res_logit, logit);
    checkOutput({tag, "_err"},   32'(bus.res_err), 32'(err));
    checkOutput({tag, "_fcnt"},  32'(frame_cnt), 32'(fcnt));
  endtask

  task automatic checkMargin(input string tag, input logic [31:0] exp);
`ifdef ARGMAX_MARGIN_EN
    checkOutput({tag, "_margin"}, bus.res_margin, exp);
`else
    if (exp == 32'hDEAD_BEEF) $display("[TB] margin %s not built", tag);
`endif
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, "_valid"},   32'(bus.res_valid), 32'd0);
    checkOutput({tag, "_cls"},     32'(bus.res_cls), 32'd0);
    checkOutput({tag, "_logit"},   bus.res_logit, 32'd0);
    checkOutput({tag, "_err"},     32'(bus.res_err), 32'd0);
    checkOutput({tag, "_overrun"}, 32'(overrun), 32'd0);
    checkOutput({tag, "_fcnt"},    32'(frame_cnt), 32'd0);
    checkMargin(tag, 32'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_cls    = '0;
    bus.in_logit  = '0;
    bus.in_last   = 1'b0;
    bus.res_ready = 1'b0;
    pulseReset();
    checkCleared("reset");

    // Mixed logits with a tie on the max: earliest class wins
    bus.res_ready = 1'b1;
    loadBasic();
    applyStimulus(NUM_CLS, 1'b1);
    checkOutput("t1_pre_valid", 32'(pre_last_valid), 32'd0);
    checkResult("t1", 2, 32'd100, 1'b0, 1);
    checkMargin("t1", 32'd0);
    @(posedge clk); #1;
    checkOutput("t1_drop", 32'(bus.res_valid), 32'd0);

    loadOrdered();
    for (int i = 0; i < NUM_CLS; i++) frm_logit[i] = 32'sh8000_0000;
    frm_logit[9] = 32'sh8000_0001;
    applyStimulus(NUM_CLS, 1'b1);
    checkResult("t2", 9, 32'h8000_0001, 1'b0, 2);
    checkMargin("t2", 32'd1);

    for (int i = 0; i < NUM_CLS; i++) frm_logit[i] = 32'sh8000_0000;
    frm_logit[0] = 32'sh7FFF_FFFF;
    applyStimulus(NUM_CLS, 1'b1);
    checkResult("t3", 0, 32'h7FFF_FFFF, 1'b0, 3);
    checkMargin("t3", 32'hFFFF_FFFF);

    // Short frame, then a clean frame starting back to back
    loadBasic();
    applyStimulus(NUM_CLS - 1, 1'b1);
    checkResult("t4_short", 2, 32'd100, 1'b1, 4);
    applyStimulus(NUM_CLS, 1'b1);
    checkResult("t4_good", 2, 32'd100, 1'b0, 5);

    loadOrdered();
    frm_cls[2] = cls_t'(3);
    frm_cls[3] = cls_t'(2);
    frm_logit = '{0, 10, 30, 20, 40, 50, 60, 70, 80, 90};
    applyStimulus(NUM_CLS, 1'b1);
    checkResult("t5_order", 9, 32'd90, 1'b1, 6);
    checkMargin("t5_order", 32'd10);

    // Two frames completing with no acceptance: overwrite and sticky overrun
    pulseReset();
    bus.res_ready = 1'b0;
    loadBasic();
    applyStimulus(NUM_CLS, 1'b1);
    checkResult("t6_a", 2, 32'd100, 1'b0, 1);
    checkOutput("t6_a_overrun", 32'(overrun), 32'd0);
    @(posedge clk); #1;
    checkResult("t6_hold", 2, 32'd100, 1'b0, 1);
    for (int i = 0; i < NUM_CLS; i++) frm_logit[i] = 32'sh8000_0000;
    frm_logit[0] = 32'sh7FFF_FFFF;
    applyStimulus(NUM_CLS, 1'b1);
    checkResult("t6_b", 0, 32'h7FFF_FFFF, 1'b0, 2);
    checkOutput("t6_b_overrun", 32'(overrun), 32'd1);
    checkMargin("t6_b", 32'hFFFF_FFFF);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    checkOutput("t6_drop", 32'(bus.res_valid), 32'd0);
    checkOutput("t6_sticky", 32'(overrun), 32'd1);

    // Pending result plus a partial frame, discarded by reset
    loadBasic();
    applyStimulus(NUM_CLS, 1'b1);
    checkOutput("t7_pending", 32'(bus.res_valid), 32'd1);
    applyStimulus(5, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_cls   = frm_cls[5];
    bus.in_logit = frm_logit[5];
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    checkCleared("t7_rst");
    bus.res_ready = 1'b1;
    applyStimulus(NUM_CLS, 1'b1);
    checkResult("t7_after", 2, 32'd100, 1'b0, 1);
    checkOutput("t7_overrun", 32'(overrun), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/argmax_result.md
Name: argmax_result

Overview:
- Downstream consumer of the FC48x10 logit stream. Takes one frame of 10 signed 32-bit logits, one per beat (class 0..9, last beat flagged), and finds the winning class and its logit.
- Presents the result on a valid/ready port to the result/UART/LED stage.
- Checks frame integrity (beat count, class order) and counts frames.

Parameters:
- NUM_CLS, 10, logits per frame.
- CLS_W, 4, class index width.
- LOGIT_W, 32, logit width (signed).
- FCNT_W, 16, frame counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-high reset; asserted = 1, sampled on the clk rising edge.
- in_valid  in  1  logit beat valid. There is no backpressure; every valid beat is consumed.
- in_cls  in  CLS_W  class index of the beat.
- in_logit  in  LOGIT_W  signed logit.
- in_last  in  1  final beat of the frame.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts the result.
- res_cls  out  CLS_W  winning class.
- res_logit  out  LOGIT_W  winning logit.
- res_err  out  1  frame malformed.
- overrun  out  1  sticky: a pending result was overwritten.
- frame_cnt  out  FCNT_W  completed frames, wraps.

Behaviour:
- Reset: all outputs 0; internal beat counter 0; running max cleared; FSM in IDLE.
- FSM (frame side):
  - IDLE → ACC on the first valid beat.
  - ACC → IDLE on a valid beat with in_last = 1.
  - A valid beat with in_last = 1 while in IDLE is a one-beat frame: it completes immediately and is flagged as an error.
- Running max:
  - The first beat of a frame loads max_val = in_logit and max_cls = in_cls.
  - Each later beat replaces the max only if in_logit > max_val (signed compare). Ties keep the lower/earlier class.
- Error flag (err_acc), set when any of these occur:
  - in_cls ≠ beat index in the frame;
  - the beat count on in_last ≠ NUM_CLS;
  - the beat count exceeds NUM_CLS before in_last. The counter saturates at NUM_CLS.
- Frame completion (valid beat with in_last = 1) at cycle N:
  - At N+1: res_valid = 1; res_cls and res_logit hold the final max, including beat N; res_err = err_acc including beat N; frame_cnt increments (wraps 2^FCNT_W−1 → 0).
  - The frame accumulator clears, so a new frame may start at N+1.
- Result handshake:
  - The result transfers on a cycle where res_valid & res_ready. res_valid drops next cycle unless a new completion occurs on the same cycle.
  - res_* stay stable while res_valid = 1 and res_ready = 0.
- Overrun: completion while res_valid = 1 and (res_ready = 0 or transfer not occurring that cycle):
  - the new result overwrites the old one;
  - res_valid stays 1;
  - overrun sets and stays 1 until reset.
  - Completion on the same cycle as a transfer is not an overrun.
- Reset mid-frame or mid-hold: the partial frame and any pending result are discarded, and overrun and frame_cnt clear. Beats arriving while rst_n = 1 are ignored.
- Latency: 1 cycle from the last beat to res_valid. Sustains back-to-back frames at one beat per cycle.

Optional Feature:
- Macro: ARGMAX_MARGIN_EN.
- When defined:
  - adds output res_margin [LOGIT_W-1:0], unsigned = max − second-highest logit;
  - saturates at 2^LOGIT_W−1 and is computed at LOGIT_W+1 bits internally;
  - a tie gives 0; a one-beat frame gives 0;
  - timing and stability are the same as res_logit.
- When undefined: the port and the second-max tracking logic are absent.

Decomposition:
- Shared package (cnn_pkg): NUM_CLS, CLS_W, LOGIT_W constants and the logit_t signed typedef, shared with fully_connected.
- One natural sub-module: argmax_cmp. It is the combinational signed compare/update of (max, second, cls) for a single beat, with tie rules, reused for the margin path.

Test Plan:
- Logits 5, −3, 100, 7, 100, 0, −1, 2, 3, 4 for classes 0..9, res_ready = 1 → res_valid 1 cycle after the last beat; res_cls = 2, res_logit = 100, res_err = 0, frame_cnt = 1; margin = 0 if ARGMAX_MARGIN_EN.
- All logits −2^31 except class 9 = −2^31+1 → res_cls = 9; margin = 1. A second frame with class 0 = 2^31−1 and the others −2^31 → margin saturates to 2^32−1.
- Frame of 9 beats with last on class 8 → res_err = 1; the next well-formed frame → res_err = 0.
- Classes sent 0, 1, 3, 2, … → res_err = 1.
- res_ready held 0 across two full frames → res_* show frame 1 then frame 2; overrun = 1; frame_cnt = 2. Then res_ready = 1 for 1 cycle → res_valid drops.
- rst_n pulsed after beat 5 of a frame → all outputs 0; the next full frame is processed correctly with frame_cnt = 1.
